data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the single-issue RISC-V core. It receives the MemRead/MemWrite strobes and the Funct3 access size produced by the main decoder, and performs byte, half-word or word loads and stores against an internal word-organised RAM after a configurable wait latency. While an access is in flight it stalls the pipeline, then returns sign- or zero-extended load data with a one-cycle Ready pulse.

## Interface
- DEPTH_WORDS, 512: RAM depth in 32-bit words; power of two.
- LATENCY, 2: BUSY wait cycles per access; legal range 1..15.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears FSM and output registers.
- MemRead  in  1  load request from the decoder.
- MemWrite  in  1  store request from the decoder.
- Funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- Addr  in  32  byte address from the ALU.
- WrData  in  32  store data; the low byte or low half is used for sb/sh.
- RdData  out  32  registered load result.
- Stall  out  1  freezes PC and pipeline registers while high.
- Ready  out  1  one-cycle pulse when an access completes.
- Fault  out  1  one-cycle pulse coincident with Ready for an illegal access.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset state is IDLE.
- **IDLE:**
  - On MemRead|MemWrite, capture Addr, Funct3, WrData and kind, load the wait counter with LATENCY-1, and go to BUSY.
  - Otherwise remain in IDLE.
- **BUSY:** decrement the counter; at 0, go to DONE.
- **DONE:** go to IDLE unconditionally. Ready=1. Fault as computed.
- **Stall:** asserted combinationally as `(IDLE && (MemRead||MemWrite)) || BUSY`. It is 0 in DONE, so the pipeline advances at the DONE edge.
- **Word index:** `captured Addr[$clog2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so accesses wrap modulo DEPTH_WORDS*4.
- **Loads:**
  - The byte or half is selected by Addr[1:0].
  - Sign-extended for 000/001, zero-extended for 100/101, full word for 010.
  - RdData is loaded on the BUSY→DONE edge and holds until the next load completes.
- **Stores:**
  - sb writes one byte lane, sh writes two lanes, sw writes all four.
  - The RAM is written on the edge leaving DONE. Other lanes are unchanged.
  - A store leaves RdData unchanged.
- **MemRead and MemWrite both high:** treated as a store.
- **Illegal Funct3:** any code not listed for the access kind (011, 110, 111 always; 100/101 for stores) sets Fault. The RAM is not written and RdData is 0.
- **RAM contents:** not reset. Contents are undefined until written.

## Timing
- **Request at cycle 0 (IDLE):**
  - Stall is high in cycles 0..LATENCY (BUSY).
  - DONE, Ready and valid RdData occur at cycle LATENCY+1.
  - Total latency is LATENCY+1 cycles from request to Ready.
- **Back-to-back requests:** a new request seen in the IDLE cycle after DONE starts immediately. Throughput is one access per LATENCY+2 cycles.
- **Reset values:** RdData=0, Stall=0 (with no request present), Ready=0, Fault=0, state=IDLE.
- **Reset asserted in BUSY or DONE:** the pending access is abandoned, no RAM write occurs, and Ready/Fault do not pulse.
- **Inputs during BUSY:** changes to inputs are ignored because the captured copies are used.

## Configuration
- **DMEM_MISALIGN_TRAP_EN defined:**
  - A half access with Addr[0]=1, or a word access with Addr[1:0]≠0, raises Fault with Ready.
  - No RAM write occurs and RdData is 0.
- **DMEM_MISALIGN_TRAP_EN not defined:**
  - Addr low bits are masked to the natural alignment (half: bit 0 cleared; word: bits 1:0 cleared) and the access proceeds.
  - Fault pulses only for illegal Funct3.

## Test plan
- **Word round trip:** LATENCY=2. sw 0xDEADBEEF to 0x10, then lw 0x10. Stall is high for 3 cycles per access; Ready pulses at cycle 3; RdData=0xDEADBEEF.
- **Byte lanes and extension:** sb 0x80 to 0x13 over a word holding 0x00000000. lb 0x13 → 0xFFFFFF80; lbu 0x13 → 0x00000080; lw 0x10 → 0x80000000.
- **Half extension:** sh 0x8001 to 0x22. lh 0x22 → 0xFFFF8001; lhu 0x22 → 0x00008001.
- **Misaligned word:** lw 0x11.
  - With DMEM_MISALIGN_TRAP_EN: Ready=Fault=1 and RdData=0.
  - Without it: the load returns the word at 0x10.
- **Reset mid-store:** sw 0x12345678 to 0x40 over a prior 0xAAAAAAAA. Assert reset in the first BUSY cycle, then lw 0x40 → 0xAAAAAAAA. Ready never pulses for the aborted store.
- **Wrap and conflict:** DEPTH_WORDS=512. sw 0x55 to 0x800, then lw 0x0 → 0x55. MemRead=MemWrite=1 with sw 0x66 to 0x4 writes 0x66 and leaves RdData unchanged.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: IDLE/BUSY/DONE access FSM over a word-organised, byte-laned RAM.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of masking Addr low bits.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        Stall,
  output logic        Ready,
  output logic        Fault
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic [3:0]           count;
  logic [IDX_W+1:0]     addr_q;
  logic [31:0]          wdata_q;
  logic [2:0]           funct3_q;
  logic                 store_q;
  logic [31:0]          ram_q;
  logic [31:0]          mem [DEPTH_WORDS];

  logic                 request;
  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic                 illegal_f3;
  logic                 fault_c;
  logic [1:0]           offset;
  logic [7:0]           lane_byte;
  logic [15:0]          lane_half;
  logic [31:0]          load_val;
  logic [3:0]           be;
  logic [31:0]          wlane;
  logic                 we;
  logic                 unused_addr;

  assign request     = MemRead | MemWrite;
  assign unused_addr = ^Addr[31:IDX_W+2];
  assign Stall       = ((state == IDLE) && request) || (state == BUSY);
  assign wr_idx      = addr_q[IDX_W+1:2];
  // The RAM read is issued from the live Addr while idle so data is ready even for LATENCY=1.
  assign rd_idx      = (state == IDLE) ? Addr[IDX_W+1:2] : wr_idx;

  always_comb begin
    case (funct3_q)
      3'b000, 3'b001, 3'b010: illegal_f3 = 1'b0;
      3'b100, 3'b101:         illegal_f3 = store_q;
      default:                illegal_f3 = 1'b1;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
  assign fault_c    = illegal_f3 | misaligned;
  assign offset     = addr_q[1:0];
`else
  assign fault_c = illegal_f3;
  always_comb begin
    case (funct3_q[1:0])
      2'b01:   offset = {addr_q[1], 1'b0};
      2'b10:   offset = 2'b00;
      default: offset = addr_q[1:0];
    endcase
  end
`endif

  always_comb begin
    case (offset)
      2'd0:    lane_byte = ram_q[7:0];
      2'd1:    lane_byte = ram_q[15:8];
      2'd2:    lane_byte = ram_q[23:16];
      default: lane_byte = ram_q[31:24];
    endcase
    lane_half = offset[1] ? ram_q[31:16] : ram_q[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
      3'b010:  load_val = ram_q;
      3'b100:  load_val = {24'd0, lane_byte};
      3'b101:  load_val = {16'd0, lane_half};
      default: load_val = 32'd0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be    = 4'b0000;
    wlane = wdata_q;
    case (funct3_q)
      3'b000: begin
        be    = 4'b0001 << offset;
        wlane = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign we = (state == DONE) && store_q && !Fault && !reset;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[wr_idx][i*8 +: 8] <= wlane[i*8 +: 8];
    end
    ram_q <= mem[rd_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      store_q  <= 1'b0;
      RdData   <= 32'd0;
      Ready    <= 1'b0;
      Fault    <= 1'b0;
    end else begin
      Ready <= 1'b0;
      Fault <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            addr_q   <= Addr[IDX_W+1:0];
            wdata_q  <= WrData;
            funct3_q <= Funct3;
            store_q  <= MemWrite;
            count    <= 4'(LATENCY - 1);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (count == 4'd0) begin
            state <= DONE;
            Ready <= 1'b1;
            Fault <= fault_c;
            if (fault_c)       RdData <= 32'd0;
            else if (!store_q) RdData <= load_val;
          end else begin
            count <= count - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: expected responses are queued at issue and
// checked by an independent monitor whenever Ready pulses.
module tb_data_mem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] Addr = 32'd0;
  logic [31:0] WrData = 32'd0;
  logic [31:0] RdData;
  logic        Stall;
  logic        Ready;
  logic        Fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        fault;
  } exp_t;
  exp_t exp_q[$];

  data_mem_responder #(.DEPTH_WORDS(512), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .Addr(Addr), .WrData(WrData),
    .RdData(RdData), .Stall(Stall), .Ready(Ready), .Fault(Fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // Monitor: one response line per Ready pulse.
  always @(negedge clk) begin
    if (!reset && Ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: got RdData=%h Fault=%b expected no response", RdData, Fault);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (RdData !== e.rd || Fault !== e.fault) begin
          errors++;
          $display("FAIL %s: got RdData=%h Fault=%b expected RdData=%h Fault=%b",
                   e.name, RdData, Fault, e.rd, e.fault);
        end else begin
          $display("resp %s: RdData=%h Fault=%b", e.name, RdData, Fault);
        end
      end
    end
  end

  task automatic access(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_fault);
    exp_t e;
    int n;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
    e.name = nm; e.rd = exp_rd; e.fault = exp_fault;
    exp_q.push_back(e);
    #1;
    n = 1;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0; Addr = 32'hFFFF_FFFF; WrData = 32'h0BAD_0BAD;
    while (Stall === 1'b1 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    chk({nm, "_stall_cycles"}, 32'(n), 32'(LAT + 1));
    chk({nm, "_ready_at_done"}, {31'd0, Ready}, 32'd1);
    @(posedge clk);
  endtask

  logic [31:0] mis_rd;
  logic        mis_fault;

  initial begin
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_rd = 32'h0000_0000; mis_fault = 1'b1;
`else
    mis_rd = 32'h8000_3C00; mis_fault = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rddata", RdData, 32'd0);
    chk("reset_stall", {31'd0, Stall}, 32'd0);
    chk("reset_ready", {31'd0, Ready}, 32'd0);
    chk("reset_fault", {31'd0, Fault}, 32'd0);
    @(negedge clk); reset = 1'b0;

    access("sw_deadbeef", 0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0000_0000, 0);
    access("lw_10",       1, 0, 3'b010, 32'h10, 32'h0,         32'hDEAD_BEEF, 0);
    access("sw_zero_10",  0, 1, 3'b010, 32'h10, 32'h0,         32'hDEAD_BEEF, 0);
    access("sb_80_13",    0, 1, 3'b000, 32'h13, 32'h0000_0080, 32'hDEAD_BEEF, 0);
    access("lb_13",       1, 0, 3'b000, 32'h13, 32'h0,         32'hFFFF_FF80, 0);
    access("lbu_13",      1, 0, 3'b100, 32'h13, 32'h0,         32'h0000_0080, 0);
    access("lw_10_b",     1, 0, 3'b010, 32'h10, 32'h0,         32'h8000_0000, 0);
    access("sb_3c_11",    0, 1, 3'b000, 32'h11, 32'hABCD_123C, 32'h8000_0000, 0);
    access("lw_10_lane",  1, 0, 3'b010, 32'h10, 32'h0,         32'h8000_3C00, 0);
    access("sh_8001_22",  0, 1, 3'b001, 32'h22, 32'h5555_8001, 32'h8000_3C00, 0);
    access("lh_22",       1, 0, 3'b001, 32'h22, 32'h0,         32'hFFFF_8001, 0);
    access("lhu_22",      1, 0, 3'b101, 32'h22, 32'h0,         32'h0000_8001, 0);
    access("lw_11_misal", 1, 0, 3'b010, 32'h11, 32'h0,         mis_rd, mis_fault);
    access("sw_aaaa_40",  0, 1, 3'b010, 32'h40, 32'hAAAA_AAAA, mis_rd, 0);

    // Store aborted by reset in its first BUSY cycle: no response is queued.
    @(negedge clk);
    MemWrite = 1'b1; Funct3 = 3'b010; Addr = 32'h40; WrData = 32'h1234_5678;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_stall", {31'd0, Stall}, 32'd0);
    chk("abort_rddata", RdData, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_ready", {31'd0, Ready}, 32'd0);
    @(negedge clk); reset = 1'b0;

    access("lw_40_kept",  1, 0, 3'b010, 32'h40,  32'h0,         32'hAAAA_AAAA, 0);
    access("sw_55_800",   0, 1, 3'b010, 32'h800, 32'h0000_0055, 32'hAAAA_AAAA, 0);
    access("lw_0_wrap",   1, 0, 3'b010, 32'h0,   32'h0,         32'h0000_0055, 0);
    access("rw_sw_66_4",  1, 1, 3'b010, 32'h4,   32'h0000_0066, 32'h0000_0055, 0);
    access("lw_4",        1, 0, 3'b010, 32'h4,   32'h0,         32'h0000_0066, 0);
    access("ld_f3_011",   1, 0, 3'b011, 32'h0,   32'h0,         32'h0000_0000, 1);
    access("st_f3_100",   0, 1, 3'b100, 32'h0,   32'h0000_0077, 32'h0000_0000, 1);
    access("lw_0_nowr",   1, 0, 3'b010, 32'h0,   32'h0,         32'h0000_0055, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("pending_responses", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
